// File: rtl/dcache_tag_ctrl.sv
// rtl/dcache_tag_ctrl.sv - data cache tag store port owner: reset sweep, arbitration, hit compare
module dcache_tag_ctrl #(
    parameter int NUM_WORDS   = 256,
    parameter int INDEX_WIDTH = $clog2(NUM_WORDS),
    parameter int TAG_WIDTH   = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int VALID_BIT   = DATA_WIDTH - 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      lookup_req_i,
    input  logic [INDEX_WIDTH-1:0]    lookup_index_i,
    input  logic [TAG_WIDTH-1:0]      lookup_tag_i,
    output logic                      lookup_gnt_o,
    output logic                      lookup_rvalid_o,
    output logic                      lookup_hit_o,
    input  logic                      update_req_i,
    input  logic [INDEX_WIDTH-1:0]    update_index_i,
    input  logic [TAG_WIDTH-1:0]      update_tag_i,
    input  logic                      update_valid_i,
    output logic                      update_gnt_o,
    input  logic                      flush_req_i,
    output logic                      flush_busy_o,
    output logic                      ts_en_o,
    output logic                      ts_we_o,
    output logic [DATA_WIDTH/8-1:0]   ts_be_o,
    output logic [INDEX_WIDTH-1:0]    ts_addr_o,
    output logic [DATA_WIDTH-1:0]     ts_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ts_rdata_i
);
    typedef enum logic {ST_FLUSH, ST_IDLE} state_e;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_WORDS - 1);

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   rvalid_q, rvalid_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [DATA_WIDTH-1:0]  upd_entry;
    logic                   unused_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            tag_q    <= tag_d;
        end
    end

    // Counter wraps to 0 on its own after LAST_IDX since NUM_WORDS is a power of two.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = lookup_gnt_o;
        tag_d    = lookup_gnt_o ? lookup_tag_i : tag_q;
        case (state_q)
            ST_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_comb begin
        upd_entry                  = '0;
        upd_entry[TAG_WIDTH-1:0]   = update_tag_i;
        upd_entry[VALID_BIT]       = update_valid_i;
    end

    always_comb begin
        lookup_gnt_o = 1'b0;
        update_gnt_o = 1'b0;
        flush_busy_o = 1'b1;
        ts_en_o      = 1'b0;
        ts_we_o      = 1'b0;
        ts_be_o      = '1;
        ts_addr_o    = '0;
        ts_wdata_o   = '0;
        if (!rst_i) begin
            case (state_q)
                ST_FLUSH: begin
                    ts_en_o   = 1'b1;
                    ts_we_o   = 1'b1;
                    ts_addr_o = cnt_q;
                end
                ST_IDLE: begin
                    flush_busy_o = 1'b0;
                    if (flush_req_i) begin
                        ts_en_o = 1'b0;
                    end else if (update_req_i) begin
                        update_gnt_o = 1'b1;
                        ts_en_o      = 1'b1;
                        ts_we_o      = 1'b1;
                        ts_addr_o    = update_index_i;
                        ts_wdata_o   = upd_entry;
                    end else if (lookup_req_i) begin
                        lookup_gnt_o = 1'b1;
                        ts_en_o      = 1'b1;
                        ts_addr_o    = lookup_index_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lookup_rvalid_o = rvalid_q && !rst_i;
    assign lookup_hit_o    = lookup_rvalid_o && ts_rdata_i[VALID_BIT]
                             && (ts_rdata_i[TAG_WIDTH-1:0] == tag_q);
    assign unused_rdata    = ^ts_rdata_i;
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb/tb_dcache_tag_ctrl.sv - directed bench for dcache_tag_ctrl with a behavioural tag store
module tb_dcache_tag_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req, lookup_gnt, lookup_rvalid, lookup_hit;
    logic [7:0]  lookup_index;
    logic [19:0] lookup_tag;
    logic        update_req, update_valid, update_gnt;
    logic [7:0]  update_index;
    logic [19:0] update_tag;
    logic        flush_req, flush_busy;
    logic        ts_en, ts_we;
    logic [3:0]  ts_be;
    logic [7:0]  ts_addr;
    logic [31:0] ts_wdata, ts_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic        seeded = 1'b0;

    always #5 clk = ~clk;

    dcache_tag_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .lookup_req_i(lookup_req), .lookup_index_i(lookup_index), .lookup_tag_i(lookup_tag),
        .lookup_gnt_o(lookup_gnt), .lookup_rvalid_o(lookup_rvalid), .lookup_hit_o(lookup_hit),
        .update_req_i(update_req), .update_index_i(update_index), .update_tag_i(update_tag),
        .update_valid_i(update_valid), .update_gnt_o(update_gnt),
        .flush_req_i(flush_req), .flush_busy_o(flush_busy),
        .ts_en_o(ts_en), .ts_we_o(ts_we), .ts_be_o(ts_be), .ts_addr_o(ts_addr),
        .ts_wdata_o(ts_wdata), .ts_rdata_i(ts_rdata)
    );

    // Unreset store: starts full of valid all-ones entries so a missed sweep shows up as hits.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hFFFF_FFFF;
            seeded   <= 1'b1;
            ts_rdata <= 32'hFFFF_FFFF;
        end else if (ts_en) begin
            if (ts_we) begin
                for (int b = 0; b < 4; b++)
                    if (ts_be[b]) mem[ts_addr][8*b +: 8] <= ts_wdata[8*b +: 8];
            end else begin
                ts_rdata <= mem[ts_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            #2;
            check("sweep_en", ts_en, 1);
            check("sweep_we", ts_we, 1);
            check("sweep_addr", ts_addr, i);
            check("sweep_wdata", ts_wdata, 0);
            check("sweep_be", ts_be, 4'hF);
            check("sweep_busy", flush_busy, 1);
            check("sweep_lgnt", lookup_gnt, 0);
            check("sweep_ugnt", update_gnt, 0);
            step();
        end
    endtask

    task automatic lookup(input logic [7:0] idx, input logic [19:0] tag, input logic exp_hit,
                          input string name);
        lookup_req   = 1'b1;
        lookup_index = idx;
        lookup_tag   = tag;
        #2;
        check({name, "_gnt"}, lookup_gnt, 1);
        check({name, "_addr"}, ts_addr, idx);
        check({name, "_we"}, ts_we, 0);
        step();
        lookup_req = 1'b0;
        #2;
        check({name, "_rvalid"}, lookup_rvalid, 1);
        check({name, "_hit"}, lookup_hit, exp_hit);
        step();
    endtask

    task automatic update(input logic [7:0] idx, input logic [19:0] tag, input logic v,
                          input logic [31:0] exp_wdata, input string name);
        update_req   = 1'b1;
        update_index = idx;
        update_tag   = tag;
        update_valid = v;
        #2;
        check({name, "_gnt"}, update_gnt, 1);
        check({name, "_wdata"}, ts_wdata, exp_wdata);
        check({name, "_addr"}, ts_addr, idx);
        check({name, "_be"}, ts_be, 4'hF);
        step();
        update_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush_req = 1'b0;
        update_req = 1'b0; update_index = 8'd0; update_tag = 20'h0; update_valid = 1'b0;
        lookup_req = 1'b1; lookup_index = 8'd5; lookup_tag = 20'h12345;
        repeat (3) step();
        #2;
        check("rst_busy", flush_busy, 1);
        check("rst_en", ts_en, 0);
        check("rst_lgnt", lookup_gnt, 0);
        check("rst_rvalid", lookup_rvalid, 0);
        step();
        rst = 1'b0;
        sweep(256);
        #2;
        check("idle_busy", flush_busy, 0);
        lookup(8'd5, 20'h12345, 1'b0, "post_sweep");
        lookup(8'd200, 20'hFFFFF, 1'b0, "garbage_cleared");

        update(8'd5, 20'h12345, 1'b1, 32'h8001_2345, "upd5");
        lookup(8'd5, 20'h12345, 1'b1, "hit5");
        lookup(8'd5, 20'h12346, 1'b0, "tagmiss5");

        update_req = 1'b1; update_index = 8'd5; update_tag = 20'h0ABCD; update_valid = 1'b1;
        lookup_req = 1'b1; lookup_index = 8'd5; lookup_tag = 20'h0ABCD;
        #2;
        check("prio_ugnt", update_gnt, 1);
        check("prio_lgnt", lookup_gnt, 0);
        check("prio_wdata", ts_wdata, 32'h8000_ABCD);
        step();
        update_req = 1'b0;
        #2;
        check("prio_lgnt_next", lookup_gnt, 1);
        step();
        lookup_req = 1'b0;
        #2;
        check("prio_rvalid", lookup_rvalid, 1);
        check("prio_hit", lookup_hit, 1);
        step();

        lookup_req = 1'b1; lookup_index = 8'd5; lookup_tag = 20'h0ABCD;
        #2;
        check("ord_lgnt", lookup_gnt, 1);
        step();
        lookup_req = 1'b0;
        update_req = 1'b1; update_index = 8'd5; update_tag = 20'h0ABCD; update_valid = 1'b0;
        #2;
        check("ord_ugnt", update_gnt, 1);
        check("ord_wdata", ts_wdata, 32'h0000_ABCD);
        check("ord_rvalid", lookup_rvalid, 1);
        check("ord_old_hit", lookup_hit, 1);
        step();
        update_req = 1'b0;
        #2;
        check("ord_rvalid_drop", lookup_rvalid, 0);
        step();
        lookup(8'd5, 20'h0ABCD, 1'b0, "after_inval");

        update_req = 1'b1; update_index = 8'd9; update_tag = 20'h00999; update_valid = 1'b1;
        #2;
        check("raw_ugnt", update_gnt, 1);
        step();
        update_req = 1'b0;
        lookup_req = 1'b1; lookup_index = 8'd9; lookup_tag = 20'h00999;
        #2;
        check("raw_lgnt", lookup_gnt, 1);
        step();
        lookup_tag = 20'h00998;
        #2;
        check("b2b_rvalid1", lookup_rvalid, 1);
        check("b2b_hit1", lookup_hit, 1);
        check("b2b_lgnt2", lookup_gnt, 1);
        step();
        lookup_req = 1'b0;
        #2;
        check("b2b_rvalid2", lookup_rvalid, 1);
        check("b2b_hit2", lookup_hit, 0);
        step();

        update(8'd5, 20'h0ABCD, 1'b1, 32'h8000_ABCD, "refill5");
        lookup_req = 1'b1; lookup_index = 8'd9; lookup_tag = 20'h00999;
        #2;
        check("pf_lgnt", lookup_gnt, 1);
        step();
        lookup_req = 1'b0;
        flush_req  = 1'b1;
        #2;
        check("fl_en", ts_en, 0);
        check("fl_lgnt", lookup_gnt, 0);
        check("fl_ugnt", update_gnt, 0);
        check("pf_rvalid", lookup_rvalid, 1);
        check("pf_hit", lookup_hit, 1);
        step();
        flush_req  = 1'b0;
        lookup_req = 1'b1;
        sweep(100);
        rst = 1'b1;
        #2;
        check("midrst_busy", flush_busy, 1);
        check("midrst_en", ts_en, 0);
        check("midrst_lgnt", lookup_gnt, 0);
        step();
        rst = 1'b0;
        sweep(256);
        lookup(8'd9, 20'h00999, 1'b0, "flushed9");
        lookup(8'd5, 20'h0ABCD, 1'b0, "flushed5");
        lookup(8'd255, 20'hFFFFF, 1'b0, "flushed255");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
